// File: rtl/bcd_field_counter.sv
// bcd_field_counter: two-digit BCD time field (seconds/minutes/hours) with
// selectable alternate range, push-button set with auto-repeat, and a
// one-cycle carry pulse when an upstream inc wraps the field from hi to lo.
module bcd_field_counter #(
  parameter int MIN_VALUE  = 0,
  parameter int MAX_VALUE  = 59,
  parameter int ALT_MIN    = 0,
  parameter int ALT_MAX    = 59,
  parameter int REP_DELAY  = 500,
  parameter int REP_PERIOD = 100
) (
  input  logic       clkin,
  input  logic       reset,
  input  logic       inc,
  input  logic       plus_n,
  input  logic       minus_n,
  input  logic       alt,
  output logic [3:0] tens,
  output logic [3:0] units,
  output logic       carry
);

  localparam int REP_MAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
  localparam int CW      = $clog2(REP_MAX + 1);

  localparam logic [6:0] NORM_LO = 7'(MIN_VALUE);
  localparam logic [6:0] NORM_HI = 7'(MAX_VALUE);
  localparam logic [6:0] ALT_LO  = 7'(ALT_MIN);
  localparam logic [6:0] ALT_HI  = 7'(ALT_MAX);

  logic [3:0]    tens_q, units_q;
  logic          carry_q;
  logic          plusPrev_q, minusPrev_q;
  logic [CW-1:0] repCnt_q;
  logic          repPhase_q;

  logic [3:0]    tens_d, units_d;
  logic          carry_d;
  logic [CW-1:0] repCnt_d;
  logic          repPhase_d;

  logic [6:0]    lo, hi, value, valueNext;
  logic [3:0]    loTens, loUnits;
  logic          plusOnly, minusOnly, press, repStep, step, outOfRange;
  logic [CW-1:0] repThresh;

  // Decode the active range, detect presses, run the repeat counter and
  // select the next field value in priority order: range fix, step, inc.
  always_comb begin
    lo        = alt ? ALT_LO : NORM_LO;
    hi        = alt ? ALT_HI : NORM_HI;
    loTens    = 4'(lo / 7'd10);
    loUnits   = 4'(lo % 7'd10);
    value     = 7'(tens_q) * 7'd10 + 7'(units_q);

    plusOnly  = ~plus_n & minus_n;
    minusOnly = ~minus_n & plus_n;
    press     = (plusOnly & plusPrev_q) | (minusOnly & minusPrev_q);
    repThresh = repPhase_q ? CW'(REP_PERIOD) : CW'(REP_DELAY);

    repStep    = 1'b0;
    repCnt_d   = '0;
    repPhase_d = 1'b0;
    if (press) begin
      repCnt_d = CW'(1);
    end else if ((plusOnly | minusOnly) && (repCnt_q != '0)) begin
      if (repCnt_q == repThresh) begin
        repStep    = 1'b1;
        repCnt_d   = CW'(1);
        repPhase_d = 1'b1;
      end else begin
        repCnt_d   = repCnt_q + CW'(1);
        repPhase_d = repPhase_q;
      end
    end
    step = press | repStep;

    outOfRange = (value > hi) || (value < lo);
    valueNext  = value;
    carry_d    = 1'b0;
    if (outOfRange) begin
      valueNext = lo;
    end else if (step) begin
      if (plusOnly) begin
        valueNext = (value == hi) ? lo : value + 7'd1;
      end else begin
        valueNext = (value == lo) ? hi : value - 7'd1;
      end
    end else if (inc) begin
      if (value == hi) begin
        valueNext = lo;
        carry_d   = 1'b1;
      end else begin
        valueNext = value + 7'd1;
      end
    end
    tens_d  = 4'(valueNext / 7'd10);
    units_d = 4'(valueNext % 7'd10);
  end

  // Register the field digits, carry, button history and repeat state;
  // reset loads lo and captures the buttons so a held button cannot step.
  always_ff @(posedge clkin) begin
    plusPrev_q  <= plus_n;
    minusPrev_q <= minus_n;
    if (reset) begin
      tens_q     <= loTens;
      units_q    <= loUnits;
      carry_q    <= 1'b0;
      repCnt_q   <= '0;
      repPhase_q <= 1'b0;
    end else begin
      tens_q     <= tens_d;
      units_q    <= units_d;
      carry_q    <= carry_d;
      repCnt_q   <= repCnt_d;
      repPhase_q <= repPhase_d;
    end
  end

  assign tens  = tens_q;
  assign units = units_q;
  assign carry = carry_q;

endmodule

// File: tb/tb_bcd_field_counter.sv
// tb_bcd_field_counter: directed checks of three field configurations:
// default 0..59, hours-style 0..23 with 1..12 alternate, and fast repeat.
module tb_bcd_field_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int assertCount = 0;
  int failCount   = 0;

  // Default configuration
  logic reset0 = 1'b1, inc0 = 1'b0, plusN0 = 1'b1, minusN0 = 1'b1, alt0 = 1'b0;
  logic [3:0] tens0, units0;
  logic carry0;

  // Hours-style configuration
  logic reset1 = 1'b1, inc1 = 1'b0, plusN1 = 1'b1, minusN1 = 1'b1, alt1 = 1'b0;
  logic [3:0] tens1, units1;
  logic carry1;

  // Fast auto-repeat configuration
  logic reset2 = 1'b1, inc2 = 1'b0, plusN2 = 1'b1, minusN2 = 1'b1, alt2 = 1'b0;
  logic [3:0] tens2, units2;
  logic carry2;

  bcd_field_counter dut0 (
    .clkin(clk), .reset(reset0), .inc(inc0), .plus_n(plusN0),
    .minus_n(minusN0), .alt(alt0), .tens(tens0), .units(units0), .carry(carry0)
  );

  bcd_field_counter #(
    .MIN_VALUE(0), .MAX_VALUE(23), .ALT_MIN(1), .ALT_MAX(12)
  ) dut1 (
    .clkin(clk), .reset(reset1), .inc(inc1), .plus_n(plusN1),
    .minus_n(minusN1), .alt(alt1), .tens(tens1), .units(units1), .carry(carry1)
  );

  bcd_field_counter #(
    .REP_DELAY(4), .REP_PERIOD(2)
  ) dut2 (
    .clkin(clk), .reset(reset2), .inc(inc2), .plus_n(plusN2),
    .minus_n(minusN2), .alt(alt2), .tens(tens2), .units(units2), .carry(carry2)
  );

  typedef struct {
    logic inc;
    logic plusN;
    logic minusN;
    logic alt;
    int   expVal;
    logic expCarry;
  } vector_t;

  vector_t vectors[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] actTens,
                             input logic [3:0] actUnits, input logic actCarry,
                             input int expVal, input logic expCarry);
    logic [3:0] expTens, expUnits;
    expTens  = 4'(expVal / 10);
    expUnits = 4'(expVal % 10);
    assertCount++;
    if (actTens !== expTens || actUnits !== expUnits || actCarry !== expCarry) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h%0h carry %b, expected %0d%0d carry %b",
               name, actTens, actUnits, actCarry, expTens, expUnits, expCarry);
    end
  endtask

  task automatic applyStimulus(input vector_t v);
    inc2   = v.inc;
    plusN2 = v.plusN;
    minusN2 = v.minusN;
    alt2   = v.alt;
    tick();
  endtask

  task automatic addVec(input logic i, input logic p, input logic m,
                        input int n, input int val);
    for (int k = 0; k < n; k++) vectors.push_back('{i, p, m, 1'b0, val, 1'b0});
  endtask

  initial begin
    // Table for the fast-repeat instance, starting from 00 after reset.
    addVec(0, 1, 1, 1, 0);
    addVec(0, 0, 1, 1, 1);
    addVec(0, 0, 1, 3, 1);
    addVec(0, 0, 1, 2, 2);
    addVec(0, 0, 1, 2, 3);
    addVec(0, 0, 1, 2, 4);
    addVec(0, 1, 1, 2, 4);
    addVec(1, 1, 1, 1, 5);
    addVec(1, 0, 1, 1, 6);
    addVec(1, 1, 1, 1, 7);
    addVec(0, 0, 0, 6, 7);
    addVec(0, 0, 1, 6, 7);
    addVec(0, 1, 1, 1, 7);
    addVec(0, 1, 0, 4, 6);
    addVec(0, 1, 0, 1, 5);
    addVec(0, 1, 1, 1, 5);

    tick();
    checkOutput("reset0", tens0, units0, carry0, 0, 1'b0);
    checkOutput("reset1", tens1, units1, carry1, 0, 1'b0);
    checkOutput("reset2", tens2, units2, carry2, 0, 1'b0);
    reset0 = 1'b0;
    reset1 = 1'b0;
    reset2 = 1'b0;

    // Table-driven vectors on the fast-repeat instance
    for (int i = 0; i < vectors.size(); i++) begin
      applyStimulus(vectors[i]);
      checkOutput($sformatf("vec%0d", i), tens2, units2, carry2,
                  vectors[i].expVal, vectors[i].expCarry);
    end

    // Button held through reset must not step, before or after deassertion
    plusN2 = 1'b0;
    reset2 = 1'b1;
    tick();
    checkOutput("holdReset0", tens2, units2, carry2, 0, 1'b0);
    tick();
    checkOutput("holdReset1", tens2, units2, carry2, 0, 1'b0);
    reset2 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      checkOutput($sformatf("holdAfter%0d", i), tens2, units2, carry2, 0, 1'b0);
    end
    plusN2 = 1'b1;
    tick();
    plusN2 = 1'b0;
    tick();
    checkOutput("freshPress", tens2, units2, carry2, 1, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    checkOutput("firstRepeat", tens2, units2, carry2, 2, 1'b0);

    // Reset mid-repeat, then keep holding: no further steps
    reset2 = 1'b1;
    tick();
    checkOutput("midRepReset", tens2, units2, carry2, 0, 1'b0);
    reset2 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      checkOutput($sformatf("midRepHold%0d", i), tens2, units2, carry2, 0, 1'b0);
    end
    plusN2 = 1'b1;
    tick();
    plusN2 = 1'b0;
    tick();
    checkOutput("rePress", tens2, units2, carry2, 1, 1'b0);
    plusN2 = 1'b1;
    tick();

    // Default instance: full wrap with a single carry pulse
    for (int i = 1; i <= 60; i++) begin
      inc0 = 1'b1;
      tick();
      checkOutput($sformatf("incWrap%0d", i), tens0, units0, carry0,
                  i % 60, (i == 60) ? 1'b1 : 1'b0);
    end
    inc0 = 1'b0;
    tick();
    checkOutput("carryOnce", tens0, units0, carry0, 0, 1'b0);

    // Decimal boundary 09 <-> 10 by buttons
    inc0 = 1'b1;
    for (int i = 0; i < 9; i++) tick();
    inc0 = 1'b0;
    tick();
    checkOutput("at09", tens0, units0, carry0, 9, 1'b0);
    plusN0 = 1'b0;
    tick();
    checkOutput("plus09to10", tens0, units0, carry0, 10, 1'b0);
    plusN0 = 1'b1;
    tick();
    minusN0 = 1'b0;
    tick();
    checkOutput("minus10to09", tens0, units0, carry0, 9, 1'b0);
    minusN0 = 1'b1;
    tick();
    minusN0 = 1'b0;
    tick();
    checkOutput("minus09to08", tens0, units0, carry0, 8, 1'b0);
    minusN0 = 1'b1;
    tick();

    // Minus wraps lo to hi without carry; back-to-back inc gives one carry
    reset0 = 1'b1;
    tick();
    reset0 = 1'b0;
    minusN0 = 1'b0;
    tick();
    checkOutput("minusWrap", tens0, units0, carry0, 59, 1'b0);
    minusN0 = 1'b1;
    inc0 = 1'b1;
    tick();
    checkOutput("b2bFirst", tens0, units0, carry0, 0, 1'b1);
    tick();
    checkOutput("b2bSecond", tens0, units0, carry0, 1, 1'b0);
    inc0 = 1'b0;
    tick();
    checkOutput("b2bIdle", tens0, units0, carry0, 1, 1'b0);

    // Hours-style instance: alternate range fix, wrap and minus wrap
    inc1 = 1'b1;
    for (int i = 0; i < 17; i++) tick();
    inc1 = 1'b0;
    tick();
    checkOutput("hoursAt17", tens1, units1, carry1, 17, 1'b0);
    alt1 = 1'b1;
    tick();
    checkOutput("altFix", tens1, units1, carry1, 1, 1'b0);
    inc1 = 1'b1;
    for (int i = 0; i < 11; i++) tick();
    checkOutput("altAt12", tens1, units1, carry1, 12, 1'b0);
    tick();
    checkOutput("altWrap", tens1, units1, carry1, 1, 1'b1);
    inc1 = 1'b0;
    tick();
    checkOutput("altIdle", tens1, units1, carry1, 1, 1'b0);
    minusN1 = 1'b0;
    tick();
    checkOutput("altMinusWrap", tens1, units1, carry1, 12, 1'b0);
    minusN1 = 1'b1;
    alt1 = 1'b0;
    tick();
    checkOutput("normKeeps12", tens1, units1, carry1, 12, 1'b0);
    alt1 = 1'b1;
    reset1 = 1'b1;
    tick();
    checkOutput("altReset", tens1, units1, carry1, 1, 1'b0);
    reset1 = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

endmodule
